arb_burst_mux: RTL and testbench

- Downstream consumer of the 4-way round-robin arbiter.
- Collects per-client valid/data streams and drives the arbiter's REQ vector.
- Captures the one-hot GNT and forwards one burst from the granted client onto a single shared valid/ready output, then releases for the next arbitration round.
- Sits between the client sources and the shared sink; the arbiter is its sidecar.

---
 rtl/arb_burst_mux.sv | 199 +++++++++++++++++++
 tb/tb_arb_burst_mux.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_burst_mux.sv
// arb_burst_mux: collects per-client valid/data streams, raises a request vector to an
// external round-robin arbiter, captures its one-hot grant and forwards a single burst
// from the granted client onto one shared valid/ready output before releasing.
module arb_burst_mux #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MAX_BURST   = 8,
    parameter int unsigned GNT_TIMEOUT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          src_valid,
    input  logic [N_REQ*DATA_W-1:0]   src_data,
    input  logic [N_REQ-1:0]          src_last,
    output logic [N_REQ-1:0]          src_ready,
    output logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ-1:0]          GNT,
    output logic                      m_valid,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_last,
    output logic [$clog2(N_REQ)-1:0]  m_src,
    input  logic                      m_ready,
    output logic                      gnt_err,
    output logic                      busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned TMO_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;

    // Terminal values: the beat that is forced to be last, and the final idle-grant cycle.
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(GNT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitGnt = 2'd1,
        StXfer    = 2'd2
    } state_e;

    // State registers.
    state_e             r_state;
    logic [N_REQ-1:0]   r_req;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_gnt_err;

    // Next-state values.
    state_e             w_state_nxt;
    logic [N_REQ-1:0]   w_req_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [CNT_W-1:0]   w_beat_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic               w_gnt_err_nxt;

    // Grant decode.
    logic               w_gnt_any;
    logic               w_gnt_multi;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_src_valid;

    // Owner-side view of the client streams.
    logic [DATA_W-1:0]  w_own_data;
    logic               w_own_valid;
    logic               w_own_last;
    logic               w_beat_last;
    logic               w_beat_xfer;

    // Reduce the grant to the lowest set index; more than one bit set is a malformed grant.
    always_comb begin
        w_gnt_any   = |GNT;
        w_gnt_multi = |(GNT & (GNT - N_REQ'(1)));
        w_gnt_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (GNT[i]) begin
                w_gnt_idx = IDX_W'(i);
            end
        end
        w_gnt_src_valid = src_valid[w_gnt_idx];
    end

    // Select the owning client's stream for the shared output.
    always_comb begin
        w_own_data  = '0;
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_data  = src_data[i*DATA_W +: DATA_W];
                w_own_valid = src_valid[i];
                w_own_last  = src_last[i];
            end
        end
        // The burst cap forces release even if the client never marks a last beat.
        w_beat_last = w_own_last | (r_beat_cnt == BEAT_LAST);
        w_beat_xfer = (r_state == StXfer) & w_own_valid & m_ready;
    end

    // Next-state logic for the request/grant/transfer sequence.
    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_owner_nxt   = r_owner;
        w_beat_nxt    = r_beat_cnt;
        w_tmo_nxt     = r_tmo_cnt;
        w_gnt_err_nxt = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (|src_valid) begin
                    w_req_nxt   = src_valid;
                    w_tmo_nxt   = '0;
                    w_state_nxt = StWaitGnt;
                end else begin
                    w_req_nxt = '0;
                end
            end

            StWaitGnt: begin
                if (!w_gnt_any) begin
                    if (r_tmo_cnt == TMO_LAST) begin
                        w_req_nxt   = '0;
                        w_state_nxt = StIdle;
                    end else begin
                        w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                    end
                end else begin
                    w_gnt_err_nxt = w_gnt_multi;
                    w_req_nxt     = '0;
                    if (w_gnt_src_valid) begin
                        w_owner_nxt = w_gnt_idx;
                        w_beat_nxt  = '0;
                        w_state_nxt = StXfer;
                    end else begin
                        // Grant to a client that has nothing to send: drop the round.
                        w_gnt_err_nxt = 1'b1;
                        w_state_nxt   = StIdle;
                    end
                end
            end

            StXfer: begin
                if (w_beat_xfer) begin
                    if (w_beat_last) begin
                        w_req_nxt   = '0;
                        w_state_nxt = StIdle;
                    end else begin
                        w_beat_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_req_nxt   = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State update; reset aborts any burst in flight without a completion beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_req      <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_gnt_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_tmo_cnt  <= w_tmo_nxt;
            r_gnt_err  <= w_gnt_err_nxt;
        end
    end

    // Combinational pass-through from the owner while transferring; quiet otherwise.
    always_comb begin
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = '0;
        src_ready = '0;
        if (r_state == StXfer) begin
            m_valid            = w_own_valid;
            m_last             = w_beat_last;
            m_data             = w_own_data;
            src_ready[r_owner] = m_ready;
        end
    end

    assign m_src   = r_owner;
    assign REQ     = r_req;
    assign gnt_err = r_gnt_err;
    assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_arb_burst_mux.sv
// tb_arb_burst_mux: directed bench; a client model feeds per-client beat queues, the bench
// plays the arbiter, and a scoreboard monitor checks every beat accepted on the output.
module tb_arb_burst_mux;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    src_valid = '0;
    logic [N*DW-1:0] src_data = '0;
    logic [N-1:0]    src_last = '0;
    logic [N-1:0]    src_ready;
    logic [N-1:0]    REQ;
    logic [N-1:0]    GNT = '0;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic [1:0]      m_src;
    logic            m_ready = 1'b1;
    logic            gnt_err;
    logic            busy;

    logic            rdy_toggle = 1'b0;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t src_q[$];   // pending client beats, in issue order
    beat_t exp_q[$];   // expected output beats, in acceptance order

    int total = 0;
    int bad   = 0;

    arb_burst_mux #(
        .N_REQ(4),
        .DATA_W(8),
        .MAX_BURST(8),
        .GNT_TIMEOUT(4)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .src_valid(src_valid),
        .src_data(src_data),
        .src_last(src_last),
        .src_ready(src_ready),
        .REQ(REQ),
        .GNT(GNT),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_last(m_last),
        .m_src(m_src),
        .m_ready(m_ready),
        .gnt_err(gnt_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Issue one beat from client c; exp_last is the hand-computed m_last, use=0 means the
    // beat is expected never to reach the output.
    task automatic push(input int c, input logic [7:0] d, input logic l, input logic exp_last,
                        input bit use_exp);
        beat_t b;
        b.c = c; b.d = d; b.l = l;
        src_q.push_back(b);
        if (use_exp) begin
            b.l = exp_last;
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_src();
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        for (int i = 0; i < N; i++) begin
            bit found = 0;
            for (int k = 0; k < src_q.size() && !found; k++) begin
                if (src_q[k].c == i) begin
                    found                 = 1;
                    src_valid[i]          = 1'b1;
                    src_data[i*DW +: DW]  = src_q[k].d;
                    src_last[i]           = src_q[k].l;
                end
            end
        end
    endtask

    task automatic pop_client(input int i);
        bit done = 0;
        for (int k = 0; k < src_q.size() && !done; k++) begin
            if (src_q[k].c == i) begin
                src_q.delete(k);
                done = 1;
            end
        end
    endtask

    // Client model: holds each beat until it is accepted, then presents the next one.
    initial begin
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = src_valid & src_ready & {N{reset}};
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) pop_client(i);
            end
            drive_src();
        end
    end

    // Sink model: ready held high, or toggled every cycle for backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_toggle ? ~m_ready : 1'b1;
        end
    end

    // Scoreboard monitor.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                total++;
                if (!$onehot0(src_ready) || (!m_ready && src_ready != '0)) begin
                    bad++;
                    $display("FAIL src_ready_rule: got %b with m_ready=%b", src_ready, m_ready);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got src=%0d data=%h last=%b want none",
                                 m_src, m_data, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat{src,last,data}", 32'({m_src, m_last, m_data}),
                              32'({e.c[1:0], e.l, e.d}));
                    end
                end
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (REQ == '0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("req_seen", 32'(REQ != '0), 32'd1);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    // Play the arbiter: wait for a request, grant for one cycle, check the resulting state.
    task automatic grant(input logic [3:0] g, input logic [3:0] exp_req, input bit ok,
                         input bit exp_err);
        wait_req();
        check("REQ_before_grant", 32'(REQ), 32'(exp_req));
        GNT = g;
        @(posedge clk);
        #1;
        GNT = '0;
        check("gnt_err", 32'(gnt_err), 32'(exp_err));
        check("post_grant{busy,REQ}", 32'({busy, REQ}), 32'({ok, 4'b0000}));
        if (!ok) check("m_valid_after_stale", 32'(m_valid), 32'd0);
        if (exp_err) begin
            @(posedge clk);
            #1;
            check("gnt_err_width", 32'(gnt_err), 32'd0);
        end
    endtask

    initial begin
        #1;
        reset = 1'b0;
        // Reset with every client requesting.
        for (int i = 0; i < N; i++) push(i, 8'(8'hE0 + i), 1'b1, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_REQ", 32'(REQ), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_src_ready", 32'(src_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt_err", 32'(gnt_err), 32'd0);
        check("rst_m_src", 32'(m_src), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("REQ_after_release", 32'(REQ), 32'hF);
        src_q.delete();
        wait_idle(20);

        // Single 3-beat burst from client 1.
        push(1, 8'hA1, 1'b0, 1'b0, 1);
        push(1, 8'hA2, 1'b0, 1'b0, 1);
        push(1, 8'hA3, 1'b1, 1'b1, 1);
        grant(4'b0010, 4'b0010, 1, 0);
        wait_idle(20);
        check("single_REQ_after", 32'(REQ), 32'd0);

        // Ten beats from client 0 under toggling ready: capped at 8, the rest in a new round.
        // Only the tenth beat carries src_last, so the second round can close.
        rdy_toggle = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push(0, 8'(8'h10 + k), 1'(k == 9), 1'(k == 7 || k == 9), 1);
        end
        grant(4'b0001, 4'b0001, 1, 0);
        wait_idle(60);
        check("cap_beats_left", 32'(exp_q.size()), 32'd2);
        grant(4'b0001, 4'b0001, 1, 0);
        wait_idle(60);
        rdy_toggle = 1'b0;

        // Round-robin chain of single-beat bursts.
        for (int i = 0; i < N; i++) push(i, 8'(8'h40 + i), 1'b1, 1'b1, 1);
        grant(4'b0001, 4'b1111, 1, 0);
        wait_idle(20);
        grant(4'b0010, 4'b1110, 1, 0);
        wait_idle(20);
        grant(4'b0100, 4'b1100, 1, 0);
        wait_idle(20);
        grant(4'b1000, 4'b1000, 1, 0);
        wait_idle(20);

        // Multi-bit grant: lowest index (client 1) wins and gnt_err pulses.
        push(1, 8'h51, 1'b1, 1'b1, 1);
        push(2, 8'h62, 1'b1, 1'b1, 1);
        grant(4'b0110, 4'b0110, 1, 1);
        wait_idle(20);
        grant(4'b0100, 4'b0100, 1, 0);
        wait_idle(20);

        // Stale grant to client 3 while only client 0 is valid.
        push(0, 8'h70, 1'b1, 1'b1, 1);
        grant(4'b1000, 4'b0001, 0, 1);
        grant(4'b0001, 4'b0001, 1, 0);
        wait_idle(20);

        // Grant timeout: four cycles of zero grant return to idle.
        push(2, 8'h82, 1'b1, 1'b1, 1);
        wait_req();
        check("tmo_REQ", 32'(REQ), 32'h4);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("tmo_still_waiting", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("tmo_{busy,REQ}", 32'({busy, REQ}), 32'd0);
        grant(4'b0100, 4'b0100, 1, 0);
        wait_idle(20);

        // Reset during beat 2: only beat 1 ever reaches the output.
        push(3, 8'h91, 1'b0, 1'b0, 1);
        push(3, 8'h92, 1'b0, 1'b0, 0);
        push(3, 8'h93, 1'b0, 1'b0, 0);
        push(3, 8'h94, 1'b1, 1'b1, 0);
        grant(4'b1000, 4'b1000, 1, 0);
        @(posedge clk);
        #2;
        check("beat2_presented", 32'({m_valid, m_data}), 32'h192);
        reset = 1'b0;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_src_ready", 32'(src_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        src_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_{busy,REQ}", 32'({busy, REQ}), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
